// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings and defaults for the pipeline hazard controller
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A source whose Tuse is 3 is not read by the D-stage instruction
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_busy_cnt.sv
// rtl/md_busy_cnt.sv - MDU occupancy countdown (load on start, decrement to zero)
module md_busy_cnt
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_is_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // Load the op latency on a qualified start, otherwise run down to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // The start cycle itself already counts as busy
  assign o_busy = (r_cnt != '0) | i_load;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline; optional perf counters under PIPE_HAZARD_CTRL_PERF_EN
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_rs_tuse,
  input  logic [1:0] D_rt_tuse,
  input  logic [4:0] E_wa,
  input  logic [1:0] E_tnew,
  input  logic [4:0] M_wa,
  input  logic [1:0] M_tnew,
  input  logic       D_is_md,
  input  logic       E_md_start,
  input  logic       E_md_is_div,
  input  logic       dbus_req,
  input  logic       dbus_ready,
  input  logic       exc_req,
  input  logic       eret_req,
  output logic       pc_en,
  output logic       D_en,
  output logic       D_clr,
  output logic       E_en,
  output logic       E_clr,
  output logic       M_en,
  output logic       M_clr,
  output logic       W_en,
  output logic       md_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  state_e r_state;
  state_e w_state_nxt;
  logic   r_flush_pend;
  logic   w_pend_nxt;

  logic w_wait;
  logic w_exc;
  logic w_flush_now;
  logic w_hz_rs;
  logic w_hz_rt;
  logic w_hz_stall;
  logic w_md_load;
  logic w_busy;
  logic w_md_stall;
  logic w_pc_en, w_d_en, w_d_clr, w_e_en, w_e_clr, w_m_en, w_m_clr, w_w_en;

  assign w_wait = dbus_req & ~dbus_ready;
  assign w_exc  = exc_req | eret_req;

  // A flush frozen by a bus wait is replayed on the cycle the wait ends
  assign w_flush_now = (r_state == ST_FLUSH) | ((r_state == ST_WAIT) & r_flush_pend);

  assign w_hz_rs = (D_rs != 5'd0) && (D_rs_tuse != TUSE_NONE) &&
                   (((D_rs == E_wa) && (E_tnew > D_rs_tuse)) ||
                    ((D_rs == M_wa) && (M_tnew > D_rs_tuse)));
  assign w_hz_rt = (D_rt != 5'd0) && (D_rt_tuse != TUSE_NONE) &&
                   (((D_rt == E_wa) && (E_tnew > D_rt_tuse)) ||
                    ((D_rt == M_wa) && (M_tnew > D_rt_tuse)));
  assign w_hz_stall = w_hz_rs | w_hz_rt;

  // Start qualifier built from the freeze/flush/register-stall terms only; the
  // MDU stall's own E_clr is left out, otherwise md_busy would feed itself
  assign w_md_load = E_md_start & ~w_wait & ~w_exc & (w_flush_now | ~w_hz_stall);

  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_md_load),
    .i_is_div(E_md_is_div),
    .o_busy  (w_busy)
  );

  assign w_md_stall = D_is_md & w_busy;

  // State register: FSM state plus the flush-pending flag held across a wait
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_pend_nxt;
    end
  end

  // Next state and pipeline controls in priority: freeze, exception, flush, stall
  always_comb begin
    w_state_nxt = ST_RUN;
    w_pend_nxt  = 1'b0;
    w_pc_en     = 1'b1;
    w_d_en      = 1'b1;
    w_d_clr     = 1'b0;
    w_e_en      = 1'b1;
    w_e_clr     = 1'b0;
    w_m_en      = 1'b1;
    w_m_clr     = 1'b0;
    w_w_en      = 1'b1;
    if (w_wait) begin
      w_state_nxt = ST_WAIT;
      w_pend_nxt  = w_flush_now;
      w_pc_en     = 1'b0;
      w_d_en      = 1'b0;
      w_e_en      = 1'b0;
      w_m_en      = 1'b0;
      w_w_en      = 1'b0;
    end else if (w_exc) begin
      w_state_nxt = ST_FLUSH;
      w_d_clr     = 1'b1;
      w_e_clr     = 1'b1;
      w_m_clr     = 1'b1;
    end else if (w_flush_now) begin
      w_d_clr     = 1'b1;
    end else if (w_md_stall | w_hz_stall) begin
      w_pc_en     = 1'b0;
      w_d_en      = 1'b0;
      w_e_clr     = 1'b1;
    end
  end

  // While reset is held the pipeline free-runs with no clears and no MDU busy
  assign pc_en   = ~reset | w_pc_en;
  assign D_en    = ~reset | w_d_en;
  assign E_en    = ~reset | w_e_en;
  assign M_en    = ~reset | w_m_en;
  assign W_en    = ~reset | w_w_en;
  assign D_clr   = reset & w_d_clr;
  assign E_clr   = reset & w_e_clr;
  assign M_clr   = reset & w_m_clr;
  assign md_busy = reset & w_busy;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic w_stall_cyc;
  assign w_stall_cyc = ~w_wait & ~w_exc & ~w_flush_now & (w_md_stall | w_hz_stall);

  // Free-running wrap-around counts of stall and freeze cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= 32'd0;
      perf_wait_cnt  <= 32'd0;
    end else begin
      if (w_stall_cyc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (w_wait)      perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] D_rs, D_rt, E_wa, M_wa;
  logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
  logic       D_is_md, E_md_start, E_md_is_div;
  logic       dbus_req, dbus_ready, exc_req, eret_req;
  logic       pc_en, D_en, D_clr, E_en, E_clr, M_en, M_clr, W_en, md_busy;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_wait_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // {pc_en, D_en, D_clr, E_en, E_clr, M_en, M_clr, W_en, md_busy}
  localparam logic [8:0] NORM    = 9'b110101010;
  localparam logic [8:0] NORM_B  = 9'b110101011;
  localparam logic [8:0] STALL   = 9'b000111010;
  localparam logic [8:0] MDSTALL = 9'b000111011;
  localparam logic [8:0] FRZ     = 9'b000000000;
  localparam logic [8:0] FRZ_B   = 9'b000000001;
  localparam logic [8:0] EXC     = 9'b111111110;
  localparam logic [8:0] FLUSH   = 9'b111101010;

  logic [8:0] obs;
  assign obs = {pc_en, D_en, D_clr, E_en, E_clr, M_en, M_clr, W_en, md_busy};

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .D_rs       (D_rs),
    .D_rt       (D_rt),
    .D_rs_tuse  (D_rs_tuse),
    .D_rt_tuse  (D_rt_tuse),
    .E_wa       (E_wa),
    .E_tnew     (E_tnew),
    .M_wa       (M_wa),
    .M_tnew     (M_tnew),
    .D_is_md    (D_is_md),
    .E_md_start (E_md_start),
    .E_md_is_div(E_md_is_div),
    .dbus_req   (dbus_req),
    .dbus_ready (dbus_ready),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .pc_en      (pc_en),
    .D_en       (D_en),
    .D_clr      (D_clr),
    .E_en       (E_en),
    .E_clr      (E_clr),
    .M_en       (M_en),
    .M_clr      (M_clr),
    .W_en       (W_en),
    .md_busy    (md_busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_wait_cnt (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Commit the current inputs on a rising edge, then return just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
    E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
    D_is_md = 1'b0; E_md_start = 1'b0; E_md_is_div = 1'b0;
    dbus_req = 1'b0; dbus_ready = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
  endtask

  task automatic hz(input logic [4:0] rs, input logic [1:0] rs_tu,
                    input logic [4:0] rt, input logic [1:0] rt_tu,
                    input logic [4:0] ewa, input logic [1:0] etn,
                    input logic [4:0] mwa, input logic [1:0] mtn,
                    input string tag, input logic [8:0] exp);
    idle();
    D_rs = rs; D_rs_tuse = rs_tu; D_rt = rt; D_rt_tuse = rt_tu;
    E_wa = ewa; E_tnew = etn; M_wa = mwa; M_tnew = mtn;
    #1 check_eq(tag, 32'(obs), 32'(exp));
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check_eq("rst_idle", 32'(obs), 32'(NORM));
    E_md_start = 1'b1; D_is_md = 1'b1;
    #1 check_eq("rst_md_start", 32'(obs), 32'(NORM));
    idle();
    tick();
    reset = 1'b1;

    // Divide in flight, reset dropped asynchronously at count 7
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    #1 check_eq("div_start", 32'(obs), 32'(NORM_B));
    tick();
    idle(); D_is_md = 1'b1;
    #1 check_eq("div_stall", 32'(obs), 32'(MDSTALL));
    tick(); tick(); tick();
    reset = 1'b0;
    #1 check_eq("rst_mid_stall", 32'(obs), 32'(NORM));
    tick();
    reset = 1'b1;
    #1 check_eq("rst_release", 32'(obs), 32'(NORM));
    tick();

    // Register hazards through E and M
    hz(5'd5, 2'd0, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, "hz_e_rs",     STALL);
    hz(5'd5, 2'd1, 5'd0, 2'd3, 5'd5, 2'd1, 5'd0, 2'd0, "hz_e_tuse_eq", NORM);
    hz(5'd0, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1, 5'd0, 2'd0, "hz_r0",       NORM);
    hz(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1, "hz_m_rt",     STALL);
    hz(5'd0, 2'd3, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd0, "hz_m_ready",  NORM);
    hz(5'd9, 2'd3, 5'd0, 2'd3, 5'd9, 2'd3, 5'd9, 2'd3, "hz_tuse_none", NORM);
    hz(5'd0, 2'd3, 5'd4, 2'd1, 5'd4, 2'd2, 5'd0, 2'd0, "hz_e_rt",     STALL);

    // Multiply: five stall cycles, then the MDU instruction advances
    idle(); E_md_start = 1'b1;
    #1 check_eq("mul_start", 32'(obs), 32'(NORM_B));
    tick();
    idle(); D_is_md = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check_eq($sformatf("mul_stall%0d", i), 32'(obs), 32'(MDSTALL));
      tick();
    end
    #1 check_eq("mul_done", 32'(obs), 32'(NORM));
    tick();

    // Divide: ten stall cycles
    idle(); E_md_start = 1'b1; E_md_is_div = 1'b1;
    #1;
    tick();
    idle(); D_is_md = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check_eq($sformatf("div_stall%0d", i), 32'(obs), 32'(MDSTALL));
      tick();
    end
    #1 check_eq("div_done", 32'(obs), 32'(NORM));
    tick();

    // Bus wait with an MDU op counting down underneath
    idle(); E_md_start = 1'b1;
    #1 check_eq("mul4_start", 32'(obs), 32'(NORM_B));
    tick();
    idle(); dbus_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq($sformatf("wait_frz%0d", i), 32'(obs), 32'(FRZ_B));
      tick();
    end
    dbus_ready = 1'b1;
    #1 check_eq("wait_end", 32'(obs), 32'(NORM_B));
    tick();
    idle(); D_is_md = 1'b1;
    #1 check_eq("md_after_wait1", 32'(obs), 32'(MDSTALL));
    tick();
    #1 check_eq("md_after_wait2", 32'(obs), 32'(NORM));
    tick();

    // Exception with a simultaneous MDU start that must not load
    idle(); exc_req = 1'b1; E_md_start = 1'b1;
    #1 check_eq("exc_run", 32'(obs), 32'(EXC));
    tick();
    idle();
    #1 check_eq("exc_flush", 32'(obs), 32'(FLUSH));
    tick();
    D_is_md = 1'b1;
    #1 check_eq("exc_no_md_load", 32'(obs), 32'(NORM));
    tick();

    // ERET, then a new exception while in FLUSH
    idle(); eret_req = 1'b1;
    #1 check_eq("eret_run", 32'(obs), 32'(EXC));
    tick();
    idle(); exc_req = 1'b1;
    #1 check_eq("exc_in_flush", 32'(obs), 32'(EXC));
    tick();
    idle();
    #1 check_eq("exc_flush2", 32'(obs), 32'(FLUSH));
    tick();
    #1 check_eq("exc_run2", 32'(obs), 32'(NORM));
    tick();

    // Exception arriving during a bus wait waits for the bus
    idle(); exc_req = 1'b1; dbus_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check_eq($sformatf("exc_wait_frz%0d", i), 32'(obs), 32'(FRZ));
      tick();
    end
    dbus_ready = 1'b1;
    #1 check_eq("exc_wait_end", 32'(obs), 32'(EXC));
    tick();
    idle();
    #1 check_eq("exc_wait_flush", 32'(obs), 32'(FLUSH));
    tick();
    #1 check_eq("exc_wait_run", 32'(obs), 32'(NORM));
    tick();

    // Bus wait landing on the FLUSH cycle: flush resumes when the bus completes
    idle(); exc_req = 1'b1;
    #1;
    tick();
    idle(); dbus_req = 1'b1;
    #1 check_eq("flush_frozen", 32'(obs), 32'(FRZ));
    tick();
    dbus_ready = 1'b1;
    #1 check_eq("flush_resumed", 32'(obs), 32'(FLUSH));
    tick();
    idle();
    #1 check_eq("flush_resume_run", 32'(obs), 32'(NORM));
    tick();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    // 3 register + 5 mult + 10 div + 1 post-wait MDU stall; 3 + 2 + 1 wait cycles
    check_eq("perf_stall", perf_stall_cnt, 32'd19);
    check_eq("perf_wait", perf_wait_cnt, 32'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
